alu_reg_sequencer: RTL and testbench

Command-driven operand/writeback stage that sits directly upstream and downstream of the 8-bit combinational ALU.
- Holds a small register file and accepts one command at a time over a valid/ready handshake.
- Drives registered operands and opcode into the ALU, then captures the ALU result and flags one cycle later.
- Writes the result back to the register file and returns it on a valid/ready response port.

---
 rtl/alu_reg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_reg_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reg_sequencer.sv
// ---------------------------------------------------------------------------
// alu_reg_sequencer
//
// Operand fetch / writeback stage wrapped around an external 8-bit
// combinational ALU. Owns a small register file, accepts one command at a
// time, presents registered operands and opcode to the ALU, captures the
// ALU result and flags one cycle later, optionally writes the result back
// and returns it on a valid/ready response port.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   cmd_valid_i/ready_o    command handshake
//   cmd_op_i               ALU opcode
//   cmd_load_i             load cmd_imm_i into rd, bypassing the ALU
//   cmd_use_imm_i          operand B from cmd_imm_i instead of rs2
//   cmd_rd_i/rs1_i/rs2_i   destination / source register indices
//   cmd_imm_i              immediate byte
//   cmd_wb_en_i            write the result into rd
//   alu_a_o/b_o/op_o       registered operands and opcode to the ALU
//   alu_result_i/flags_i   ALU result and flags {V,C,N,Z}
//   rsp_valid_o/ready_i    response handshake
//   rsp_result_o/flags_o   captured result and flag register {V,C,N,Z}
//   op_count_o             completed response count, wraps
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready_o=1, waiting for a command
// EXEC  | operands stable on the ALU; result captured at end of cycle
// RESP  | rsp_valid_o=1, holding the response until rsp_ready_i
// ---------------------------------------------------------------------------
module alu_reg_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic              cmd_load_i,
    input  logic              cmd_use_imm_i,
    input  logic [REG_AW-1:0] cmd_rd_i,
    input  logic [REG_AW-1:0] cmd_rs1_i,
    input  logic [REG_AW-1:0] cmd_rs2_i,
    input  logic [7:0]        cmd_imm_i,
    input  logic              cmd_wb_en_i,

    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [7:0]        alu_result_i,
    input  logic [3:0]        alu_flags_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [7:0]        rsp_result_o,
    output logic [3:0]        rsp_flags_o,
    output logic [CNT_W-1:0]  op_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];

    logic [7:0]          alu_a_q, alu_a_d;
    logic [7:0]          alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;

    // Command fields needed after acceptance
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                wb_en_q, wb_en_d;
    logic                load_q, load_d;
    logic [7:0]          imm_q, imm_d;

    logic [7:0]          rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;

    logic [7:0]          wb_val;

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        wb_en_d      = wb_en_q;
        load_d       = load_q;
        imm_d        = imm_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        op_count_d   = op_count_q;
        wb_val       = load_q ? imm_q : alu_result_i;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    // Operands are snapshot here; no command is in flight,
                    // so the register file cannot change underneath them.
                    alu_a_d  = regs_q[cmd_rs1_i];
                    alu_b_d  = cmd_use_imm_i ? cmd_imm_i : regs_q[cmd_rs2_i];
                    alu_op_d = cmd_op_i;
                    rd_d     = cmd_rd_i;
                    wb_en_d  = cmd_wb_en_i;
                    load_d   = cmd_load_i;
                    imm_d    = cmd_imm_i;
                    state_d  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                rsp_result_d = wb_val;
                // A load does not touch the flag register.
                if (!load_q) begin
                    rsp_flags_d = alu_flags_i;
                end
                if (wb_en_q) begin
                    regs_d[rd_q] = wb_val;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered, derived from the next state.
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rd_q         <= '0;
            wb_en_q      <= 1'b0;
            load_q       <= 1'b0;
            imm_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            wb_en_q      <= wb_en_d;
            load_q       <= load_d;
            imm_q        <= imm_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            op_count_q   <= op_count_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_reg_sequencer. Provides a behavioural 8-bit ALU on the
// DUT's ALU ports and keeps a reference register file, flag register and
// response counter. The counter width is reduced to 8 bits so that a wrap
// happens within a short run.
// ---------------------------------------------------------------------------
module tb_alu_reg_sequencer;

    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [2:0]    cmd_op_i;
    logic          cmd_load_i;
    logic          cmd_use_imm_i;
    logic [1:0]    cmd_rd_i;
    logic [1:0]    cmd_rs1_i;
    logic [1:0]    cmd_rs2_i;
    logic [7:0]    cmd_imm_i;
    logic          cmd_wb_en_i;
    logic [7:0]    alu_a_o;
    logic [7:0]    alu_b_o;
    logic [2:0]    alu_op_o;
    logic [7:0]    alu_result_i;
    logic [3:0]    alu_flags_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [7:0]    rsp_result_o;
    logic [3:0]    rsp_flags_o;
    logic [CW-1:0] op_count_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]    ref_regs [4];
    logic [3:0]    ref_flags;
    logic [CW-1:0] ref_count;

    alu_reg_sequencer #(.NUM_REGS(4), .REG_AW(2), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_load_i    (cmd_load_i),
        .cmd_use_imm_i (cmd_use_imm_i),
        .cmd_rd_i      (cmd_rd_i),
        .cmd_rs1_i     (cmd_rs1_i),
        .cmd_rs2_i     (cmd_rs2_i),
        .cmd_imm_i     (cmd_imm_i),
        .cmd_wb_en_i   (cmd_wb_en_i),
        .alu_a_o       (alu_a_o),
        .alu_b_o       (alu_b_o),
        .alu_op_o      (alu_op_o),
        .alu_result_i  (alu_result_i),
        .alu_flags_i   (alu_flags_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_flags_o   (rsp_flags_o),
        .op_count_o    (op_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU: returns {V,C,N,Z,result}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        int   sa, sb, sr;
        logic [7:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
        sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
        case (op)
            3'd0: begin
                r  = 8'((int'(a) + int'(b)) % 256);
                c  = (int'(a) + int'(b)) > 255;
                sr = sa + sb;
                v  = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                r  = 8'((int'(a) - int'(b) + 256) % 256);
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > 127) || (sr < -128);
            end
            3'd2: begin r = 8'((int'(a) * 2) % 256); c = (a >= 8'd128); end
            3'd3: begin r = 8'(int'(a) / 2);         c = (int'(a) % 2) == 1; end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = ~a;
            default: r = a;
        endcase
        return {v, c, (r >= 8'd128), (r == 8'd0), r};
    endfunction

    always_comb {alu_flags_i, alu_result_i} = alu_fn(alu_a_o, alu_b_o, alu_op_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_flags = 4'h0;
        ref_count = '0;
    endtask

    // Runs one full command: acceptance, EXEC, RESP with 'stall' cycles of
    // backpressure, then the response handshake. Entered just after a negedge.
    task automatic do_cmd(input logic [2:0] op, input logic load, input logic use_imm,
                          input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [7:0] imm, input logic wb, input int stall,
                          output logic [7:0] r_out, output logic [3:0] f_out);
        logic [7:0]  a, b, er;
        logic [3:0]  ef;
        logic [11:0] fr;
        int w;
        w = 0;
        while (!cmd_ready_o && w < 8) begin
            @(negedge clk_i);
            w++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);

        cmd_op_i      = op;
        cmd_load_i    = load;
        cmd_use_imm_i = use_imm;
        cmd_rd_i      = rd;
        cmd_rs1_i     = rs1;
        cmd_rs2_i     = rs2;
        cmd_imm_i     = imm;
        cmd_wb_en_i   = wb;
        cmd_valid_i   = 1'b1;
        rsp_ready_i   = 1'($urandom_range(0, 1));

        a = ref_regs[rs1];
        b = use_imm ? imm : ref_regs[rs2];
        fr = alu_fn(a, b, op);
        if (load) begin
            er = imm;
            ef = ref_flags;
        end else begin
            er = fr[7:0];
            ef = fr[11:8];
        end

        @(posedge clk_i);
        #1;
        // Junk command while busy must be ignored.
        cmd_valid_i = 1'($urandom_range(0, 1));
        cmd_rd_i    = 2'($urandom_range(0, 3));
        cmd_imm_i   = 8'($urandom_range(0, 255));

        @(negedge clk_i);
        chk("exec_alu_a", 32'(alu_a_o), 32'(a));
        chk("exec_alu_b", 32'(alu_b_o), 32'(b));
        chk("exec_alu_op", 32'(alu_op_o), 32'(op));
        chk("exec_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("exec_cmd_ready", 32'(cmd_ready_o), 32'd0);

        @(negedge clk_i);
        chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rsp_result", 32'(rsp_result_o), 32'(er));
        chk("rsp_flags", 32'(rsp_flags_o), 32'(ef));
        chk("rsp_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rsp_count_hold", 32'(op_count_o), 32'(ref_count));
        r_out = rsp_result_o;
        f_out = rsp_flags_o;

        if (wb) ref_regs[rd] = er;
        ref_flags = ef;

        for (int s = 0; s < stall; s++) begin
            rsp_ready_i = 1'b0;
            cmd_valid_i = 1'b1;
            @(negedge clk_i);
            chk("stall_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_result", 32'(rsp_result_o), 32'(er));
            chk("stall_flags", 32'(rsp_flags_o), 32'(ef));
            chk("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
            chk("stall_count", 32'(op_count_o), 32'(ref_count));
        end

        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'($urandom_range(0, 1));
        cmd_valid_i = 1'b0;
        ref_count   = ref_count + 1'b1;

        @(negedge clk_i);
        chk("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("op_count", 32'(op_count_o), 32'(ref_count));
        if (ref_count == '0) chk("count_wrap", 32'(op_count_o), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] f;

        rst_ni        = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_op_i      = 3'd0;
        cmd_load_i    = 1'b0;
        cmd_use_imm_i = 1'b0;
        cmd_rd_i      = 2'd0;
        cmd_rs1_i     = 2'd0;
        cmd_rs2_i     = 2'd0;
        cmd_imm_i     = 8'd0;
        cmd_wb_en_i   = 1'b0;
        rsp_ready_i   = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_alu_a", 32'(alu_a_o), 32'd0);
        chk("rst_alu_b", 32'(alu_b_o), 32'd0);
        chk("rst_alu_op", 32'(alu_op_o), 32'd0);
        chk("rst_result", 32'(rsp_result_o), 32'd0);
        chk("rst_flags", 32'(rsp_flags_o), 32'd0);
        chk("rst_count", 32'(op_count_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Populate registers, then reset in the middle of EXEC
        for (int i = 0; i < 4; i++)
            do_cmd(3'd0, 1'b1, 1'b0, 2'(i), 2'd0, 2'd0, 8'(8'h11 * (i + 1)), 1'b1, 0, r, f);
        do_cmd(3'd1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 8'h00, 1'b1, 0, r, f);
        cmd_op_i = 3'd0; cmd_load_i = 1'b0; cmd_use_imm_i = 1'b0;
        cmd_rd_i = 2'd3; cmd_rs1_i = 2'd1; cmd_rs2_i = 2'd2; cmd_wb_en_i = 1'b1;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("midrst_count", 32'(op_count_o), 32'd0);
        chk("midrst_alu_a", 32'(alu_a_o), 32'd0);
        chk("midrst_result", 32'(rsp_result_o), 32'd0);
        chk("midrst_flags", 32'(rsp_flags_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("midrst_no_rsp", 32'(rsp_valid_o), 32'd0);
        rst_ni = 1'b1;
        model_reset();
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            do_cmd(3'd7, 1'b0, 1'b0, 2'd0, 2'(i), 2'd0, 8'h00, 1'b0, 0, r, f);
            chk("reg_cleared", 32'(r), 32'd0);
        end

        // Load then ADD: FF + 01 -> 00 with C and Z
        do_cmd(3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b1, 0, r, f);
        do_cmd(3'd0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 0, r, f);
        do_cmd(3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 0, r, f);
        chk("add_ff_01_result", 32'(r), 32'h00);
        chk("add_ff_01_flags", 32'(f), 32'b0101);
        do_cmd(3'd7, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 8'h00, 1'b0, 0, r, f);
        chk("add_ff_01_r2", 32'(r), 32'h00);

        // ADD immediate: 7F + 01 -> 80 with V and N; a load keeps the flags
        do_cmd(3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'h7F, 1'b1, 0, r, f);
        do_cmd(3'd0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd3, 8'h01, 1'b1, 0, r, f);
        chk("addi_result", 32'(r), 32'h80);
        chk("addi_flags", 32'(f), 32'b1010);
        do_cmd(3'd5, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0, 8'h55, 1'b1, 0, r, f);
        chk("load_result", 32'(r), 32'h55);
        chk("load_keeps_flags", 32'(f), 32'b1010);

        // Backpressure for 5 cycles
        do_cmd(3'd5, 1'b0, 1'b0, 2'd2, 2'd0, 2'd3, 8'h00, 1'b1, 5, r, f);
        chk("bp_result", 32'(r), 32'h7F);

        // Writeback disabled: rd keeps its old value
        do_cmd(3'd0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 8'hF0, 1'b1, 0, r, f);
        do_cmd(3'd0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd0, 8'h3C, 1'b1, 0, r, f);
        do_cmd(3'd4, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0, 0, r, f);
        chk("and_nowb_result", 32'(r), 32'h30);
        do_cmd(3'd7, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 0, r, f);
        chk("and_nowb_rd_kept", 32'(r), 32'hF0);

        // Randomized traffic; crosses the counter wrap
        for (int n = 0; n < 300; n++) begin
            do_cmd(3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)),
                   ($urandom_range(0, 4) != 0),
                   int'($urandom_range(0, 3)),
                   r, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
